// File: rtl/logic_pkg.sv
// Op encodings and elaboration helpers for the bitwise reduction pipeline.
package logic_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;

    typedef enum logic [1:0] {
        BASE_AND,
        BASE_OR,
        BASE_XOR
    } base_e;

    function automatic logic op_identity(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_NAND);
    endfunction

    function automatic base_e op_base(input logic [2:0] op);
        if ((op == OP_AND) || (op == OP_NAND)) return BASE_AND;
        if ((op == OP_XOR) || (op == OP_XNOR)) return BASE_XOR;
        return BASE_OR;
    endfunction

    function automatic logic op_inverts(input logic [2:0] op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

    function automatic logic op_reserved(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic int clog3(input int n);
        int s;
        int p;
        s = 1;
        p = 3;
        for (int i = 0; i < 16; i++) begin
            if (p < n) begin
                p = p * 3;
                s = s + 1;
            end
        end
        return s;
    endfunction

    // Operand count entering stage k.
    function automatic int group_count(input int n, input int k);
        int c;
        c = n;
        for (int i = 0; i < k; i++) c = (c + 2) / 3;
        return c;
    endfunction

endpackage

// File: rtl/logic_reduce_stage.sv
// One registered 3:1 reduction stage with a valid/ready register;
// the op code rides along so every stage knows its base op.
module logic_reduce_stage
    import logic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_IN  = 6
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [2:0]                       in_op,
    input  logic [N_IN*WIDTH-1:0]            in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [2:0]                       out_op,
    output logic [((N_IN+2)/3)*WIDTH-1:0]    out_data
);

    localparam int N_OUT = (N_IN + 2) / 3;

    logic [3*N_OUT*WIDTH-1:0] padded;
    logic [N_OUT*WIDTH-1:0]   data_d;
    logic [N_OUT*WIDTH-1:0]   data_q;
    logic [2:0]               op_q;
    logic                     valid_q;
    logic [WIDTH-1:0]         acc;
    logic [WIDTH-1:0]         opnd;

    // The short last group is padded with the base op's identity.
    always_comb begin
        padded = {(3*N_OUT*WIDTH){op_identity(in_op)}};
        padded[N_IN*WIDTH-1:0] = in_data;
    end

    always_comb begin
        data_d = '0;
        acc    = '0;
        opnd   = '0;
        for (int g = 0; g < N_OUT; g++) begin
            acc = {WIDTH{op_identity(in_op)}};
            for (int j = 0; j < 3; j++) begin
                opnd = padded[(3*g+j)*WIDTH +: WIDTH];
                unique case (op_base(in_op))
                    BASE_AND: acc = acc & opnd;
                    BASE_XOR: acc = acc ^ opnd;
                    default:  acc = acc | opnd;
                endcase
            end
            data_d[g*WIDTH +: WIDTH] = acc;
        end
    end

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_op    = op_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op_q    <= OP_AND;
            data_q  <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (in_ready) begin
                valid_q <= in_valid;
            end
            if (in_valid && in_ready && !flush) begin
                op_q   <= in_op;
                data_q <= data_d;
            end
        end
    end

endmodule

// File: rtl/logic_reduce_pipe.sv
// Pipelined N-operand bitwise reduction: mask/identity substitution,
// a chain of 3:1 stages, then inversion and flags on the held result.
module logic_reduce_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_op,
    input  logic [NUM_IN-1:0]       in_mask,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_any,
    output logic                    out_all
);

    localparam int STAGES = clog3(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] sub_data;
    logic [WIDTH-1:0]        last_d;
    logic [2:0]              last_op;

    always_comb begin
        sub_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            sub_data[i*WIDTH +: WIDTH] = in_mask[i] ? in_data[i*WIDTH +: WIDTH]
                                                    : {WIDTH{op_identity(in_op)}};
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int NI = group_count(NUM_IN, k);
        localparam int NO = (NI + 2) / 3;

        logic              v_i;
        logic              r_o;
        logic              v_o;
        logic              r_i;
        logic [2:0]        op_i;
        logic [2:0]        op_o;
        logic [NI*WIDTH-1:0] d_i;
        logic [NO*WIDTH-1:0] d_o;

        if (k == 0) begin : g_src
            assign v_i  = in_valid;
            assign op_i = in_op;
            assign d_i  = sub_data;
        end else begin : g_lnk
            assign v_i  = g_st[k-1].v_o;
            assign op_i = g_st[k-1].op_o;
            assign d_i  = g_st[k-1].d_o;
        end

        if (k == STAGES - 1) begin : g_snk
            assign r_i = out_ready;
        end else begin : g_nxt
            assign r_i = g_st[k+1].r_o;
        end

        logic_reduce_stage #(
            .WIDTH (WIDTH),
            .N_IN  (NI)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_valid  (v_i),
            .in_ready  (r_o),
            .in_op     (op_i),
            .in_data   (d_i),
            .out_valid (v_o),
            .out_ready (r_i),
            .out_op    (op_o),
            .out_data  (d_o)
        );
    end

    assign in_ready  = g_st[0].r_o & ~flush;
    assign out_valid = g_st[STAGES-1].v_o;
    assign last_op   = g_st[STAGES-1].op_o;
    assign last_d    = g_st[STAGES-1].d_o;

    // Inversion is applied only to the fully reduced base result.
    always_comb begin
        out_err  = op_reserved(last_op);
        out_data = op_inverts(last_op) ? ~last_d : last_d;
        if (out_err) out_data = '0;
    end

    assign out_any = |out_data;
    assign out_all = &out_data;

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Scoreboard bench for logic_reduce_pipe: directed cases plus random
// traffic checked against a flat per-operand reference model.
module tb_logic_reduce_pipe;

    localparam int W = 32;
    localparam int N = 6;

    typedef struct packed {
        logic        err;
        logic [31:0] d;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [N-1:0] in_mask;
    logic [N*W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_err;
    logic         out_any;
    logic         out_all;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   pops  = 0;
    exp_t sb[$];
    int   pop_cyc[$];

    logic_reduce_pipe #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_mask   (in_mask),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_any   (out_any),
        .out_all   (out_all)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [N-1:0] m,
                                   input logic [N*W-1:0] d);
        exp_t e;
        logic [31:0] acc;
        logic [31:0] x;
        e.err = 1'b0;
        e.d   = '0;
        if (op > 3'd5) begin
            e.err = 1'b1;
            return e;
        end
        acc = (op == 3'd0 || op == 3'd3) ? 32'hFFFF_FFFF : 32'h0;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                x = d[i*W +: W];
                case (op)
                    3'd0, 3'd3: acc = acc & x;
                    3'd1, 3'd4: acc = acc | x;
                    default:    acc = acc ^ x;
                endcase
            end
        end
        e.d = (op >= 3'd3) ? ~acc : acc;
        return e;
    endfunction

    // Monitor: pops on every output transfer and checks stall stability.
    logic        held = 1'b0;
    logic [31:0] h_d;
    logic        h_err;
    logic        h_any;
    logic        h_all;
    exp_t        me;

    always begin
        @(negedge clk);
        #4;
        if (rst_n && out_valid) begin
            if (held) begin
                chk("stall_data", out_data, h_d);
                chk("stall_err", out_err, h_err);
                chk("stall_flags", {out_any, out_all}, {h_any, h_all});
            end
            if (out_ready && !flush) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out got=%h want=none", out_data);
                end else begin
                    me = sb.pop_front();
                    chk("sb_data", out_data, me.d);
                    chk("sb_err", out_err, me.err);
                    chk("sb_any", out_any, |me.d);
                    chk("sb_all", out_all, &me.d);
                    pops++;
                    pop_cyc.push_back(cyc);
                end
            end
        end
        held  = rst_n && out_valid && !out_ready && !flush;
        h_d   = out_data;
        h_err = out_err;
        h_any = out_any;
        h_all = out_all;
    end

    // All driver tasks start at a falling edge and end at a falling edge.
    task automatic offer(input logic [2:0] op, input logic [N-1:0] m,
                         input logic [N*W-1:0] d, output bit acc);
        in_valid = 1'b1;
        in_op    = op;
        in_mask  = m;
        in_data  = d;
        #4;
        acc = in_ready && rst_n && !flush;
        if (acc) sb.push_back(model(op, m, d));
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] op, input logic [N-1:0] m,
                        input logic [N*W-1:0] d);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) offer(op, m, d, acc);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout got=0 want=1");
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #4;
            if (out_valid) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s got=timeout want=valid", nm);
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 3))
            0: return ~(32'h1 << $urandom_range(0, 31));
            1: return 32'h1 << $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit acc;
        int got;
        int idx;
        int p0;
        logic [N*W-1:0] items [4];
        logic [N*W-1:0] rd;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd0;
        in_mask   = '1;
        in_data   = '1;
        out_ready = 1'b1;

        repeat (2) begin
            @(negedge clk);
            #4;
            chk("rst_valid", out_valid, 0);
            chk("rst_data", out_data, 0);
            chk("rst_ready", in_ready, 1);
            chk("rst_flags", {out_err, out_any, out_all}, 0);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        offer(3'd0, 6'h3F, {32'hFFFF_0FFF, {5{32'hFFFF_FFFF}}}, acc);
        chk("and_accept", acc, 1);
        in_valid = 1'b0;
        #4;
        chk("lat1_valid", out_valid, 0);
        @(negedge clk);
        #4;
        chk("lat2_valid", out_valid, 1);
        chk("and_data", out_data, 32'hFFFF_0FFF);
        chk("and_all", out_all, 0);
        chk("and_any", out_any, 1);
        @(negedge clk);

        rd = {32'h1234_5678, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'h0F0F_0F0F,
              32'h0000_00FF, 32'h0000_00F0};
        send(3'd5, 6'b000011, rd);
        wait_valid("xnor_wait");
        chk("xnor_data", out_data, 32'hFFFF_FFF0);
        @(negedge clk);
        send(3'd5, 6'b000000, rd);
        wait_valid("xnor0_wait");
        chk("xnor0_data", out_data, 32'hFFFF_FFFF);
        @(negedge clk);
        drain();

        pop_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < N; j++) rd[j*W +: W] = rnd_opnd();
            offer((i == 3) ? 3'd6 : ((i == 2) ? 3'd4 : 3'(i)), 6'h3F, rd, acc);
            chk("b2b_accept", acc, 1);
        end
        drain();
        chk("b2b_count", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4) chk("b2b_consec", pop_cyc[3] - pop_cyc[0], 3);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < N; j++) items[i][j*W +: W] = $urandom;
        end
        got = 0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            offer(3'(idx % 3), 6'h3F, items[idx], acc);
            if (acc) begin
                got++;
                idx++;
            end
        end
        chk("stall_accepted", got, 2);
        #4;
        chk("stall_in_ready", in_ready, 0);
        @(negedge clk);
        p0 = pops;
        drain();
        chk("stall_drained", pops - p0, 2);

        out_ready = 1'b0;
        send(3'd1, 6'h3F, {N{32'h0000_0011}});
        send(3'd2, 6'h3F, {N{32'h0000_0101}});
        flush    = 1'b1;
        in_valid = 1'b1;
        #4;
        chk("flush_in_ready", in_ready, 0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        #4;
        chk("flush_valid", out_valid, 0);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) begin
            #4;
            chk("flush_ghost", out_valid, 0);
            @(negedge clk);
        end

        out_ready = 1'b0;
        send(3'd0, 6'h3F, {N{32'hFFFF_FFFF}});
        send(3'd1, 6'h3F, {N{32'h0000_0F00}});
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        sb.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            #4;
            chk("arst_ghost", out_valid, 0);
            @(negedge clk);
        end

        acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!acc && $urandom_range(0, 3) != 0) begin
                in_op   = 3'($urandom_range(0, 7));
                in_mask = 6'($urandom);
                for (int j = 0; j < N; j++) in_data[j*W +: W] = rnd_opnd();
                acc = 1'b1;
            end
            in_valid = acc;
            #4;
            if (acc && in_ready) begin
                sb.push_back(model(in_op, in_mask, in_data));
                acc = 1'b0;
            end
            @(negedge clk);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

endmodule
